hs_sink_counter: RTL and testbench
==================================

// Module: hs_sink_counter
// PURPOSE
//  Clocked 4-phase handshake sink at the downstream end of the self-timed counter chain.
//  Consumes the last stage's request (ro) and returns its acknowledge (ao).
//  Counts completed handshakes for the synchronous testbench/monitor side.
//  Provides the boundary between the asynchronous counter and the clocked model domain.
// PARAMETERS
//  CNT_W       16  width of the handshake count
//  SYNC_STAGES 2   flops in the req_in synchronizer (>=2)
//  ACK_DELAY   2   extra cycles between synchronized req rise and ack rise (0..15)
// PORTS
//  clk       in   1      single clock; all state on rising edge
//  reset     in   1      asynchronous, active-high reset
//  req_in    in   1      request from last counter stage (ro); asynchronous to clk
//  ack_out   out  1      acknowledge to last counter stage (ao); driven from a flop
//  enable    in   1      1 = accept new handshakes; 0 = hold in IDLE
//  clr       in   1      synchronous clear of count
//  count     out  CNT_W  number of completed handshakes, modulo 2^CNT_W
//  wrap      out  1      one-cycle pulse when count goes all-ones -> 0
//  busy      out  1      1 whenever FSM is not IDLE
//  err       out  1      sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, ack_out=0, count=0, wrap=0, busy=0, err=0, sync flops=0
//  req_s = req_in after SYNC_STAGES flops; only req_s is used internally
//  FSM:
//   IDLE:  ack_out=0; req_s=1 & enable=1 -> DELAY (ACK_DELAY>0) or ACK (ACK_DELAY=0)
//   DELAY: counts ACK_DELAY cycles, then -> ACK
//   ACK:   ack_out=1; stay until req_s=0; then ack_out<=0, count<=count+1 -> IDLE
//  Latency: req_in rise to ack_out rise = SYNC_STAGES+ACK_DELAY+1 cycles (ACK_DELAY=0 -> SYNC_STAGES+1)
//  Latency: req_in fall to ack_out fall = SYNC_STAGES+1 cycles; count updates on the same edge
//  Sink never raises ack_out while req_s=0 and never lowers it while req_s=1
//  enable=0: IDLE does not leave; in-flight handshake (DELAY/ACK) completes normally
//  Count wraps 2^CNT_W-1 -> 0 with wrap=1 for exactly that cycle; no saturation
//  clr=1: count<=0, wrap=0; clr and increment on the same edge -> clr wins (count=0)
//  clr has no effect on the FSM or ack_out
//  Reset mid-handshake: ack_out drops immediately
//   If req_in is still high after reset release, a new handshake starts from IDLE
//   That handshake is counted once; no double count
//  busy is combinational from FSM state
// CONFIGURATION
//  HS_SINK_PROTOCOL_CHECK_EN defined:
//   err<=1 (sticky until reset) if req_s falls in DELAY (request withdrawn before ack)
//   The FSM then returns to IDLE without incrementing count
//  HS_SINK_PROTOCOL_CHECK_EN undefined:
//   err tied to 0
//   req_s fall in DELAY is ignored; the FSM proceeds to ACK and waits for req_s=0 (already
//   true), so ack_out pulses for 1 cycle and count increments
// TESTING
//  T1 reset: reset=1 with req_in=1 -> ack_out=0, count=0, busy=0; release -> ack_out=1 after 5 cycles (defaults)
//  T2 single handshake, defaults: req_in 0->1 -> ack_out=1 at cycle 5; req_in 1->0 -> ack_out=0 at cycle 3, count=1
//  T3 wrap, CNT_W=4: 16 handshakes -> count 15->0 on 16th, wrap=1 for one cycle, 0 otherwise
//  T4 enable: enable=0, req_in=1 for 20 cycles -> ack_out stays 0; enable=1 -> ack_out=1 after ACK_DELAY+1 cycles
//  T4 enable (cont.): enable=0 while in ACK -> handshake completes, count+1
//  T5 clr race: clr=1 on the edge where req_s falls in ACK -> count=0, ack_out=0
//  T6 check (macro on): req_in pulse of 3 cycles, ACK_DELAY=8 -> err=1, count unchanged, ack_out never 1
//  T6 check (macro off): same stimulus -> err=0, one-cycle ack_out pulse, count=1

Source files
------------

// File: rtl/hs_sink_counter.sv
// Clocked 4-phase handshake sink that terminates the self-timed counter chain and counts handshakes.
// Optional protocol checking (sticky err on a withdrawn request) is enabled by defining HS_SINK_PROTOCOL_CHECK_EN.
module hs_sink_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  output logic             ack_out,
  input  logic             enable,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             busy,
  output logic             err
);

  // 4-phase handshake: the sink raises ack_out only after seeing req high,
  // holds it until req is seen low, then drops it; that drop completes one handshake.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [3:0]             dly_cnt;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sync_q  <= '0;
      dly_cnt <= '0;
      ack_out <= 1'b0;
      count   <= '0;
      wrap    <= 1'b0;
`ifdef HS_SINK_PROTOCOL_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      wrap   <= 1'b0;
      if (clr) begin
        count <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (req_s && enable) begin
            if (ACK_DELAY == 0) begin
              state   <= ST_ACK;
              ack_out <= 1'b1;
            end else begin
              state   <= ST_DELAY;
              dly_cnt <= '0;
            end
          end
        end
        ST_DELAY: begin
`ifdef HS_SINK_PROTOCOL_CHECK_EN
          if (!req_s) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else
`endif
          if (dly_cnt == DLY_LAST) begin
            state   <= ST_ACK;
            ack_out <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            ack_out <= 1'b0;
            state   <= ST_IDLE;
            // clr on the completing edge takes priority over the increment
            if (!clr) begin
              count <= count + 1'b1;
              wrap  <= &count;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          ack_out <= 1'b0;
        end
      endcase
    end
  end

`ifndef HS_SINK_PROTOCOL_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_sink_counter.sv
// Directed bench for hs_sink_counter: default instance, a 4-bit/no-delay instance for wrap,
// and an ACK_DELAY=8 instance for the withdrawn-request case.
module tb_hs_sink_counter;

  logic clk;
  logic reset;

  logic        req_a, en_a, clr_a, ack_a, wrap_a, busy_a, err_a;
  logic [15:0] cnt_a;
  logic        req_w, ack_w, wrap_w, busy_w, err_w;
  logic [3:0]  cnt_w;
  logic        req_d, ack_d, wrap_d, busy_d, err_d;
  logic [15:0] cnt_d;

  int n_checks;
  int n_errors;
  int cyc;
  int seen;
  int ack_cyc;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hs_sink_counter dut_a (
    .clk(clk), .reset(reset), .req_in(req_a), .ack_out(ack_a), .enable(en_a),
    .clr(clr_a), .count(cnt_a), .wrap(wrap_a), .busy(busy_a), .err(err_a)
  );

  hs_sink_counter #(.CNT_W(4), .SYNC_STAGES(2), .ACK_DELAY(0)) dut_w (
    .clk(clk), .reset(reset), .req_in(req_w), .ack_out(ack_w), .enable(1'b1),
    .clr(1'b0), .count(cnt_w), .wrap(wrap_w), .busy(busy_w), .err(err_w)
  );

  hs_sink_counter #(.CNT_W(16), .SYNC_STAGES(2), .ACK_DELAY(8)) dut_d (
    .clk(clk), .reset(reset), .req_in(req_d), .ack_out(ack_d), .enable(1'b1),
    .clr(1'b0), .count(cnt_d), .wrap(wrap_d), .busy(busy_d), .err(err_d)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycles until the selected ack reaches level; bounded at 64
  task automatic wait_ack(input int sel, input logic level, output int cycles);
    logic cur;
    cycles = 0;
    cur = (sel == 0) ? ack_a : ((sel == 1) ? ack_w : ack_d);
    while (cur !== level && cycles < 64) begin
      tick(1);
      cycles++;
      cur = (sel == 0) ? ack_a : ((sel == 1) ? ack_w : ack_d);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    req_a = 1'b1;
    en_a  = 1'b1;
    clr_a = 1'b0;
    req_w = 1'b0;
    req_d = 1'b0;

    // T1: reset held with req high, then release
    tick(3);
    check("t1_ack_rst", ack_a, 0);
    check("t1_cnt_rst", cnt_a, 0);
    check("t1_busy_rst", busy_a, 0);
    check("t1_wrap_rst", wrap_a, 0);
    check("t1_err_rst", err_a, 0);
    check("t1_err_d_rst", err_d, 0);
    reset = 1'b0;
    wait_ack(0, 1'b1, cyc);
    check("t1_rise_lat", cyc, 5);
    check("t1_cnt_hold", cnt_a, 0);
    req_a = 1'b0;
    wait_ack(0, 1'b0, cyc);
    check("t1_fall_lat", cyc, 3);
    check("t1_cnt_once", cnt_a, 1);
    tick(1);
    check("t1_busy_idle", busy_a, 0);

    // T2: single handshake with defaults
    req_a = 1'b1;
    wait_ack(0, 1'b1, cyc);
    check("t2_rise_lat", cyc, 5);
    check("t2_busy", busy_a, 1);
    check("t2_cnt_hold", cnt_a, 1);
    req_a = 1'b0;
    wait_ack(0, 1'b0, cyc);
    check("t2_fall_lat", cyc, 3);
    check("t2_cnt", cnt_a, 2);

    // T4: enable low holds IDLE, then in-flight completion with enable low
    en_a  = 1'b0;
    req_a = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack_a || busy_a) seen = 1;
    end
    check("t4_hold_idle", seen, 0);
    en_a = 1'b1;
    wait_ack(0, 1'b1, cyc);
    check("t4_en_lat", cyc, 3);
    en_a  = 1'b0;
    req_a = 1'b0;
    wait_ack(0, 1'b0, cyc);
    check("t4_fall_lat", cyc, 3);
    check("t4_cnt", cnt_a, 3);
    en_a = 1'b1;

    // T5: clr during ACK leaves the FSM alone; clr on the completing edge wins
    req_a = 1'b1;
    wait_ack(0, 1'b1, cyc);
    check("t5a_rise_lat", cyc, 5);
    tick(1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t5a_cnt_clr", cnt_a, 0);
    check("t5a_ack_kept", ack_a, 1);
    check("t5a_busy_kept", busy_a, 1);
    req_a = 1'b0;
    wait_ack(0, 1'b0, cyc);
    check("t5a_fall_lat", cyc, 3);
    check("t5a_cnt", cnt_a, 1);
    req_a = 1'b1;
    wait_ack(0, 1'b1, cyc);
    check("t5b_rise_lat", cyc, 5);
    req_a = 1'b0;
    tick(2);
    check("t5b_ack_pre", ack_a, 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t5b_ack_race", ack_a, 0);
    check("t5b_cnt_race", cnt_a, 0);
    check("t5b_wrap_race", wrap_a, 0);

    // T3: wrap on a 4-bit count
    for (int i = 0; i < 16; i++) begin
      req_w = 1'b1;
      wait_ack(1, 1'b1, cyc);
      check("t3_rise_lat", cyc, 3);
      req_w = 1'b0;
      wait_ack(1, 1'b0, cyc);
      check("t3_fall_lat", cyc, 3);
      check("t3_wrap", wrap_w, (i == 15) ? 1 : 0);
      check("t3_cnt", cnt_w, (i + 1) % 16);
    end
    tick(1);
    check("t3_wrap_one_cycle", wrap_w, 0);

    // T6: request withdrawn during an 8-cycle delay
    req_d = 1'b1;
    tick(3);
    req_d = 1'b0;
    ack_cyc = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (ack_d) ack_cyc++;
    end
`ifdef HS_SINK_PROTOCOL_CHECK_EN
    check("t6_err", err_d, 1);
    check("t6_cnt", cnt_d, 0);
    check("t6_ack_cycles", ack_cyc, 0);
`else
    check("t6_err", err_d, 0);
    check("t6_cnt", cnt_d, 1);
    check("t6_ack_cycles", ack_cyc, 1);
`endif
    check("t6_busy", busy_d, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
